// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential halfword fetches, tags returning
// data with its PC, and presents a DEPTH-entry FIFO to decode with redirect flush.
module fetch_queue #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       redirect_valid_i,
  input  logic [PC_W-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [PC_W-1:0]            imem_addr_o,
  input  logic [INSTR_W-1:0]         imem_data_i,
  output logic                       instr_valid_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [PC_W-1:0]            instr_pc_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] queue_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           push;
  logic           pop;

  // Credit counts the slot reserved by the inflight response; a same-cycle pop
  // is deliberately not credited to keep the request path off instr_ready_i.
  assign occupancy  = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign imem_req_o = !reset_i && !redirect_valid_i && (occupancy < (CNT_W+1)'(DEPTH));
  assign push       = inflight_q && !redirect_valid_i;
  assign pop        = (count_q != '0) && instr_ready_i && !redirect_valid_i;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = pc_q;
    inflight_d = imem_req_o;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i & ~PC_W'(1);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req_o) pc_d = pc_q + PC_W'(2);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; count gating keeps stale entries invisible.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      instr_mem_q[wr_ptr_q] <= imem_data_i;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign instr_valid_o = !reset_i && (count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign queue_count_o = reset_i ? '0 : count_q;
  assign imem_addr_o   = reset_i ? RESET_PC : pc_q;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Cycle-based bench for fetch_queue: memory model answers one cycle after each
// request, a reference model predicts requests and the expected PC stream.
module tb_fetch_queue;
  localparam int              PC_W     = 32;
  localparam int              INSTR_W  = 16;
  localparam int              DEPTH    = 4;
  localparam int              CNT_W    = $clog2(DEPTH+1);
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               redirect_valid_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               instr_ready_i;
  logic [CNT_W-1:0]   queue_count_o;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .queue_count_o(queue_count_o)
  );

  int errors = 0;
  int checks = 0;

  logic [PC_W-1:0] exp_q [$];
  logic [PC_W-1:0] m_pc;
  logic            m_pend;
  logic [PC_W-1:0] m_pend_pc;
  logic            mem_req_q;
  logic [PC_W-1:0] mem_addr_q;

  function automatic logic [INSTR_W-1:0] mem_f(input logic [PC_W-1:0] a);
    return INSTR_W'(a >> 1) ^ INSTR_W'(16'h3C5A);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, advance the model.
  task automatic cycle(input logic rst, input logic redir, input logic [PC_W-1:0] rpc,
                       input logic rdy);
    logic exp_req;
    reset_i          = rst;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    instr_ready_i    = rdy;
    imem_data_i      = mem_req_q ? mem_f(mem_addr_q) : INSTR_W'($urandom);
    #1;
    exp_req = !rst && !redir && ((exp_q.size() + int'(m_pend)) < DEPTH);
    check_eq("req", 64'(imem_req_o), 64'(exp_req));
    check_eq("addr", 64'(imem_addr_o), rst ? 64'(RESET_PC) : 64'(m_pc));
    check_eq("count", 64'(queue_count_o), rst ? 64'd0 : 64'(exp_q.size()));
    check_eq("valid", 64'(instr_valid_o), 64'(!rst && exp_q.size() != 0));
    if (!rst && exp_q.size() != 0) begin
      check_eq("head_pc", 64'(instr_pc_o), 64'(exp_q[0]));
      check_eq("head_instr", 64'(instr_o), 64'(mem_f(exp_q[0])));
    end else begin
      check_eq("empty_pc", 64'(instr_pc_o), 64'd0);
      check_eq("empty_instr", 64'(instr_o), 64'd0);
    end
    mem_req_q  = imem_req_o;
    mem_addr_q = imem_addr_o;
    if (rst) begin
      exp_q.delete();
      m_pend = 1'b0;
      m_pc   = RESET_PC;
    end else if (redir) begin
      exp_q.delete();
      m_pend = 1'b0;
      m_pc   = {rpc[PC_W-1:1], 1'b0};
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (m_pend) exp_q.push_back(m_pend_pc);
      m_pend    = exp_req;
      m_pend_pc = m_pc;
      if (exp_req) m_pc = m_pc + PC_W'(2);
    end
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, rdy);
  endtask

  initial begin
    reset_i          = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    instr_ready_i    = 1'b0;
    imem_data_i      = '0;
    mem_req_q        = 1'b0;
    mem_addr_q       = '0;
    m_pc             = RESET_PC;
    m_pend           = 1'b0;
    m_pend_pc        = '0;
    @(negedge clk_i);
    @(negedge clk_i);

    // Release with ready high: streaming at one per cycle.
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    run(14, 1'b1);

    // Decode stalled from release until the queue fills, then drains.
    cycle(1'b1, 1'b0, '0, 1'b0);
    run(8, 1'b0);
    run(10, 1'b1);

    // Redirect to an odd target with 3 queued and one inflight.
    cycle(1'b1, 1'b0, '0, 1'b0);
    run(4, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0101, 1'b0);
    run(8, 1'b1);

    // Redirect coinciding with a pop handshake, then a held redirect.
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    run(6, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    run(6, 1'b1);

    // PC wrap at the top of the address space plus pointer wrap.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    run(16, 1'b1);

    // One-cycle reset mid-stream with 2 queued and 1 inflight.
    cycle(1'b1, 1'b0, '0, 1'b0);
    run(3, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    run(12, 1'b1);

    // Random mix of stalls, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0)
        cycle(1'b1, 1'b0, '0, 1'($urandom));
      else if ($urandom_range(15) == 0)
        cycle(1'b0, 1'b1, PC_W'($urandom), 1'($urandom));
      else
        cycle(1'b0, 1'b0, '0, $urandom_range(3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
